// File: rtl/imem_boot_ctrl_if.sv
// Loader / instruction-memory write / core-control bundle for imem_boot_ctrl.
// master = loader side, slave = boot controller.
interface imem_boot_ctrl_if #(
  parameter int unsigned AW = 10
);
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          load_err;
  logic [AW:0]   byte_count;

  modport master (
    output ld_start, ld_valid, ld_byte, ld_last,
    input  ld_ready, mem_we, mem_waddr, mem_wdata,
    input  core_hold, busy, load_err, byte_count
  );

  modport slave (
    input  ld_start, ld_valid, ld_byte, ld_last,
    output ld_ready, mem_we, mem_waddr, mem_wdata,
    output core_hold, busy, load_err, byte_count
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/reload controller: streams loader bytes into instruction memory and holds the core until done.
// Optional trailing checksum byte check enabled by defining IMEM_CHECKSUM_EN.
module imem_boot_ctrl #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned AW       = 10
) (
  input logic             clk,
  input logic             reset,
  imem_boot_ctrl_if.slave bus
);
  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          hold_q,  hold_d;
  logic          busy_q,  busy_d;
  logic          ready_q, ready_d;
  logic          err_q,   err_d;
  logic          xfer_c;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // State and registered outputs; reset leaves the core held with nothing loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end
`endif

  // Next state; ld_start always wins and restarts the session without writing.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    xfer_c  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end

      S_LOAD: begin
        if (bus.ld_start) begin
          count_d = '0;
        end else if (bus.ld_valid && ready_q) begin
          xfer_c  = 1'b1;
          count_d = count_q + CW'(1);
`ifdef IMEM_CHECKSUM_EN
          sum_d   = 8'(sum_q + bus.ld_byte);
          if (bus.ld_last)
            state_d = S_CHECK;
`else
          if (bus.ld_last)
            state_d = S_RUN;
`endif
          else if (count_q == LAST_ADDR)
            state_d = S_ERROR;
        end
      end

`ifdef IMEM_CHECKSUM_EN
      // Consume the checksum byte without writing it.
      S_CHECK: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end else if (bus.ld_valid && ready_q) begin
          state_d = (8'(sum_q + bus.ld_byte) == 8'h00) ? S_RUN : S_ERROR;
        end
      end
`endif

      S_RUN, S_ERROR: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

`ifdef IMEM_CHECKSUM_EN
    if (bus.ld_start)
      sum_d = '0;
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    busy_d  = (state_d == S_LOAD);
`endif
    ready_d = busy_d;
    hold_d  = (state_d != S_RUN);
    err_d   = (state_d == S_ERROR);
  end

  assign bus.ld_ready   = ready_q;
  assign bus.core_hold  = hold_q;
  assign bus.busy       = busy_q;
  assign bus.load_err   = err_q;
  assign bus.byte_count = count_q;

  // Memory write port is a zero-latency pass-through of the accepted byte.
  assign bus.mem_we     = xfer_c;
  assign bus.mem_waddr  = count_q[AW-1:0];
  assign bus.mem_wdata  = bus.ld_byte;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected memory writes queued by the driver, checked by a monitor.
module tb_imem_boot_ctrl;
  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned AW       = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk;
  logic reset;
  imem_boot_ctrl_if #(.AW(AW)) bus ();

  imem_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t           exp_q[$];
  int            n_cmp;
  int            n_err;
  logic [AW-1:0] tb_addr;
  logic [7:0]    tb_sum;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  // Monitor: every memory write must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      n_cmp++;
      if (!bus.ld_ready) begin
        n_err++;
        $display("FAIL we_without_ready: mem_we=1 while ld_ready=0 addr=%0d", bus.mem_waddr);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%0d data=0x%02h, expected no write",
                 bus.mem_waddr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.addr != bus.mem_waddr || e.data != bus.mem_wdata) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                   bus.mem_waddr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    tb_addr = '0;
    tb_sum  = '0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    exp_q.push_back('{addr: tb_addr, data: b});
    tb_addr = tb_addr + AW'(1);
    tb_sum  = 8'(tb_sum + b);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Trailing checksum byte (only when the checksum feature is built in).
  task automatic finish_ok();
`ifdef IMEM_CHECKSUM_EN
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'(8'h00 - tb_sum);
    tick();
    bus.ld_valid = 1'b0;
`endif
  endtask

  task automatic idle_valid(input int cycles);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hA5;
    repeat (cycles) tick();
    bus.ld_valid = 1'b0;
  endtask

  logic [7:0] prog [8];
  int         gaps [6];

  initial begin
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    gaps = '{0, 2, 1, 0, 3, 1};
    n_cmp = 0;
    n_err = 0;
    tb_addr = '0;
    tb_sum  = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = 8'h00;
    bus.ld_last  = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) tick();

    chk("rst_core_hold", int'(bus.core_hold), 1);
    chk("rst_ld_ready", int'(bus.ld_ready), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_load_err", int'(bus.load_err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_byte_count", int'(bus.byte_count), 0);
    reset = 1'b0;

    // Idle for 20 cycles with ld_valid noise: no writes, core stays held.
    idle_valid(20);
    chk("idle_core_hold", int'(bus.core_hold), 1);
    chk("idle_ld_ready", int'(bus.ld_ready), 0);

    // First program load.
    start();
    chk("load_ready", int'(bus.ld_ready), 1);
    chk("load_busy", int'(bus.busy), 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("hold_before_last", int'(bus.core_hold), 1);
      send(prog[i], i == 7);
    end
    finish_ok();
    chk("run_core_hold", int'(bus.core_hold), 0);
    chk("run_byte_count", int'(bus.byte_count), 8);
    chk("run_busy", int'(bus.busy), 0);
    chk("run_ready", int'(bus.ld_ready), 0);
    chk("run_drain", exp_q.size(), 0);

    idle_valid(3);
    chk("run_ignores_valid", int'(bus.core_hold), 0);

    // Reload from RUN with gapped ld_valid.
    start();
    chk("reload_hold", int'(bus.core_hold), 1);
    chk("reload_count_clr", int'(bus.byte_count), 0);
    for (int i = 0; i < 6; i++) begin
      repeat (gaps[i]) tick();
      send(8'(8'h20 + i), i == 5);
    end
    finish_ok();
    chk("gap_byte_count", int'(bus.byte_count), 6);
    chk("gap_core_hold", int'(bus.core_hold), 0);
    chk("gap_drain", exp_q.size(), 0);

    // Short 4-byte reload.
    start();
    chk("reload4_hold", int'(bus.core_hold), 1);
    for (int i = 0; i < 4; i++) send(8'(8'hC0 | i), i == 3);
    finish_ok();
    chk("reload4_count", int'(bus.byte_count), 4);
    chk("reload4_hold_off", int'(bus.core_hold), 0);
    chk("reload4_drain", exp_q.size(), 0);

    // Overflow: fill the whole memory without ld_last.
    start();
    for (int i = 0; i < int'(MEM_SIZE); i++) send(8'(i * 7 + 3), 1'b0);
    chk("ovf_load_err", int'(bus.load_err), 1);
    chk("ovf_core_hold", int'(bus.core_hold), 1);
    chk("ovf_ready", int'(bus.ld_ready), 0);
    chk("ovf_busy", int'(bus.busy), 0);
    chk("ovf_byte_count", int'(bus.byte_count), int'(MEM_SIZE));
    chk("ovf_drain", exp_q.size(), 0);
    idle_valid(3);
    chk("err_sticky", int'(bus.load_err), 1);

    start();
    chk("err_cleared", int'(bus.load_err), 0);
    chk("err_restart_busy", int'(bus.busy), 1);

    // Restart mid-load: ld_start with ld_valid must not write.
    for (int i = 0; i < 3; i++) send(8'(8'h50 + i), 1'b0);
    chk("midload_count", int'(bus.byte_count), 3);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hEE;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    tb_addr = '0;
    tb_sum  = '0;
    chk("restart_count_clr", int'(bus.byte_count), 0);
    chk("restart_busy", int'(bus.busy), 1);
    send(8'h61, 1'b0);
    send(8'h62, 1'b1);
    finish_ok();
    chk("restart_count", int'(bus.byte_count), 2);
    chk("restart_run", int'(bus.core_hold), 0);
    chk("restart_drain", exp_q.size(), 0);

`ifdef IMEM_CHECKSUM_EN
    // Good checksum: 0x01 + 0x02 + 0xFD == 0.
    start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    chk("cks_in_check_hold", int'(bus.core_hold), 1);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hFD;
    tick();
    bus.ld_valid = 1'b0;
    chk("cks_good_run", int'(bus.core_hold), 0);
    chk("cks_good_err", int'(bus.load_err), 0);
    chk("cks_good_count", int'(bus.byte_count), 2);

    // Bad checksum.
    start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hFE;
    tick();
    bus.ld_valid = 1'b0;
    chk("cks_bad_err", int'(bus.load_err), 1);
    chk("cks_bad_hold", int'(bus.core_hold), 1);
    chk("cks_drain", exp_q.size(), 0);
`endif

    // Async reset mid-load returns to the held idle state.
    start();
    send(8'h77, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hold", int'(bus.core_hold), 1);
    chk("async_rst_count", int'(bus.byte_count), 0);
    chk("async_rst_ready", int'(bus.ld_ready), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot/reload controller for the instruction path. It owns the byte-wide write port of the instruction memory and streams program bytes from a loader (UART/debug bridge) into it. While loading, it holds the core in reset and stalls the PC register; when loading completes, it releases the core to fetch from address 0. It sits between the loader interface and the PC / instruction-memory / PC+4 fetch datapath.

Parameters:
MEM_SIZE, 1024, instruction memory size in bytes; must be a power of two and at least 4.
AW, 10, write address width; must equal log2(MEM_SIZE).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ld_start  input  1  one-cycle pulse: begin a (re)load session
ld_valid  input  1  loader byte valid
ld_byte  input  8  loader byte, in ascending address order (LSB of each word first)
ld_last  input  1  qualifies the final program byte (sampled with ld_valid)
ld_ready  output  1  controller accepts a byte this cycle
mem_we  output  1  instruction-memory byte write enable
mem_waddr  output  AW  byte write address
mem_wdata  output  8  byte write data
core_hold  output  1  holds the core in reset and drives the PC stall input
busy  output  1  a load session is in progress
load_err  output  1  sticky error flag, cleared by ld_start
byte_count  output  AW+1  number of bytes written in the last or current session

Behaviour:
- Reset is asynchronous. All outputs go to 0 except core_hold=1. State goes to IDLE; the address counter goes to 0.
- States: IDLE, LOAD, [CHECK], RUN, ERROR.
- IDLE: core_hold=1, ld_ready=0. Stay in IDLE until ld_start, then go to LOAD. After reset the core never runs until one load completes.
- LOAD: busy=1, core_hold=1, ld_ready=1.
  - A byte transfers when ld_valid and ld_ready are both high.
  - Same cycle as the transfer: mem_we=1, mem_waddr=counter, mem_wdata=ld_byte. The write is combinational from the inputs, with zero added latency.
  - The counter and byte_count increment on the clock edge after each transfer.
  - ld_last on a transfer: go to RUN, or to CHECK if IMEM_CHECKSUM_EN is defined.
  - Overflow: a transfer at counter = MEM_SIZE-1 without ld_last writes the byte, then goes to ERROR. The address does not wrap into a further write.
- RUN: core_hold=0, busy=0, ld_ready=0. The first fetch happens at PC=0 on the cycle after core_hold falls.
- ld_start while in RUN (reload):
  - core_hold rises on the next edge.
  - The counter and byte_count clear, load_err clears, and the state goes to LOAD.
  - The core restarts from 0 after the new load.
- ld_start while in LOAD or CHECK: restart the session. The counter clears and no byte is written that cycle, even if ld_valid is high.
- ERROR: core_hold=1, load_err=1, ld_ready=0. Only ld_start (go to LOAD) or reset leaves ERROR.
- ld_valid outside LOAD is ignored, with mem_we=0.
- Reset mid-load: the controller returns to IDLE immediately. Already-written memory contents are undefined to software and must be reloaded.
- mem_we is never asserted when ld_ready=0.

Optional Feature:
IMEM_CHECKSUM_EN
- Defined: the controller keeps an 8-bit running sum (mod 256) of the program bytes. After ld_last it enters CHECK with ld_ready=1 and consumes one more byte, which is never written (mem_we=0). If the sum plus that byte equals 8'h00, go to RUN; otherwise go to ERROR.
- Not defined: there is no CHECK state. ld_last goes directly to RUN and no checksum byte is expected.

Test Plan:
- Reset, then check outputs: core_hold=1, ld_ready=0, mem_we=0, load_err=0. The core stays held for 20 cycles with no ld_start.
- ld_start, then 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with ld_last on the 8th -> writes to addresses 0..7 in order, byte_count=8, RUN entered, core_hold falls one cycle after the 8th transfer.
- ld_valid toggled randomly during load -> writes occur only on valid&&ready cycles, with addresses contiguous.
- 1024 bytes without ld_last -> all 1024 written, then ERROR with load_err=1 and core_hold=1. A following ld_start clears load_err.
- In RUN, pulse ld_start and load 4 bytes -> core_hold=1 next cycle, the address restarts at 0, byte_count=4, then RUN again.
- IMEM_CHECKSUM_EN: bytes 0x01,0x02 (last) plus checksum 0xFD -> RUN with no write of 0xFD. Checksum 0xFE instead -> ERROR, load_err=1.
